// File: rtl/timer_pkg.sv
// Shared encodings and BCD limits for the countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_RING   = 2'd3
    } state_t;

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

    // True when a digit is a legal BCD value no larger than lim.
    function automatic logic digit_le(input logic [DIGIT_W-1:0] d,
                                      input logic [DIGIT_W-1:0] lim);
        return d <= lim;
    endfunction

endpackage

// File: rtl/bcd_down_cnt_2d.sv
// Two-digit BCD down counter with load and borrow chaining.
module bcd_down_cnt_2d
    import timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] TENS_WRAP = SEC_TENS_MAX,
    parameter logic [DIGIT_W-1:0] ONES_WRAP = DIGIT_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld1,
    input  logic [DIGIT_W-1:0] ld0,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d0,
    output logic               is_zero,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] d1_q, d1_d;
    logic [DIGIT_W-1:0] d0_q, d0_d;

    // Next digit values: load overrides decrement; ones wrap borrows from tens.
    always_comb begin
        d1_d = d1_q;
        d0_d = d0_q;
        if (load) begin
            d1_d = ld1;
            d0_d = ld0;
        end else if (en) begin
            if (d0_q == '0) begin
                d0_d = ONES_WRAP;
                d1_d = (d1_q == '0) ? TENS_WRAP : d1_q - DIGIT_W'(1);
            end else begin
                d0_d = d0_q - DIGIT_W'(1);
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= '0;
            d0_q <= '0;
        end else begin
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign d1         = d1_q;
    assign d0         = d0_q;
    assign is_zero    = (d1_q == '0) && (d0_q == '0);
    assign borrow_out = en & is_zero;

endmodule

// File: rtl/cnt_down_timer_bcd.sv
// HH:MM:SS BCD countdown timer with pause, latched ring and load validation.
module cnt_down_timer_bcd
    import timer_pkg::*;
#(
    parameter logic [7:0] H_MAX = 8'h23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_h1,
    input  logic [DIGIT_W-1:0] ld_h0,
    input  logic [DIGIT_W-1:0] ld_m1,
    input  logic [DIGIT_W-1:0] ld_m0,
    input  logic [DIGIT_W-1:0] ld_s1,
    input  logic [DIGIT_W-1:0] ld_s0,
    input  logic               start,
    input  logic               pause,
    input  logic               ack,
    output logic [DIGIT_W-1:0] h1,
    output logic [DIGIT_W-1:0] h0,
    output logic [DIGIT_W-1:0] m1,
    output logic [DIGIT_W-1:0] m0,
    output logic [DIGIT_W-1:0] s1,
    output logic [DIGIT_W-1:0] s0,
    output logic               running,
    output logic               done,
    output logic               ring,
    output logic               err
);

    state_t state_q, state_d;
    logic   dec, ld_en, err_d, done_d;
    logic   ld_valid;
    logic   s_zero, m_zero, h_zero, count_zero, one_sec;
    logic   s_borrow, m_borrow, hr_borrow_unused;
    logic   running_q, ring_q, done_q, err_q;

    // Load digits must be BCD with six-limited tens for minutes/seconds and hours <= H_MAX.
    assign ld_valid = digit_le(ld_h1, DIGIT_MAX) && digit_le(ld_h0, DIGIT_MAX) &&
                      digit_le(ld_m1, SEC_TENS_MAX) && digit_le(ld_m0, DIGIT_MAX) &&
                      digit_le(ld_s1, SEC_TENS_MAX) && digit_le(ld_s0, DIGIT_MAX) &&
                      ({ld_h1, ld_h0} <= H_MAX);

    bcd_down_cnt_2d #(.TENS_WRAP(SEC_TENS_MAX), .ONES_WRAP(DIGIT_MAX)) u_sec (
        .clk(clk), .rst(rst), .en(dec), .load(ld_en), .ld1(ld_s1), .ld0(ld_s0),
        .d1(s1), .d0(s0), .is_zero(s_zero), .borrow_out(s_borrow)
    );

    bcd_down_cnt_2d #(.TENS_WRAP(SEC_TENS_MAX), .ONES_WRAP(DIGIT_MAX)) u_min (
        .clk(clk), .rst(rst), .en(s_borrow), .load(ld_en), .ld1(ld_m1), .ld0(ld_m0),
        .d1(m1), .d0(m0), .is_zero(m_zero), .borrow_out(m_borrow)
    );

    // Hours never borrow out: the FSM stops the count at zero.
    bcd_down_cnt_2d #(.TENS_WRAP(H_MAX[7:4]), .ONES_WRAP(DIGIT_MAX)) u_hr (
        .clk(clk), .rst(rst), .en(m_borrow), .load(ld_en), .ld1(ld_h1), .ld0(ld_h0),
        .d1(h1), .d0(h0), .is_zero(h_zero), .borrow_out(hr_borrow_unused)
    );

    assign count_zero = h_zero & m_zero & s_zero;
    assign one_sec    = h_zero & m_zero & (s1 == '0) & (s0 == DIGIT_W'(1));

    // Next-state, counter control and pulse generation.
    always_comb begin
        state_d = state_q;
        dec     = 1'b0;
        ld_en   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    ld_en = ld_valid;
                    err_d = !ld_valid;
                end else if (start && !count_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    dec = 1'b1;
                    if (one_sec) state_d = S_RING;
                end
            end
            S_PAUSED: begin
                if (load) begin
                    ld_en = ld_valid;
                    err_d = !ld_valid;
                    if (ld_valid) state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RING: begin
                if (load) begin
                    ld_en = ld_valid;
                    err_d = !ld_valid;
                end
                if (ack || (load && ld_valid)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_RING) && (state_q != S_RING);
    end

    // State and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            ring_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == S_RUN);
            ring_q    <= (state_d == S_RING);
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign running = running_q;
    assign ring    = ring_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_cnt_down_timer_bcd.sv
// Directed bench for the BCD countdown timer.
module tb_cnt_down_timer_bcd;

    logic       clk, rst, tick, load, start, pause, ack;
    logic [3:0] ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       running, done, ring, err;

    int checks = 0;
    int errors = 0;

    cnt_down_timer_bcd #(.H_MAX(8'h23)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_h1(ld_h1), .ld_h0(ld_h0), .ld_m1(ld_m1), .ld_m0(ld_m0),
        .ld_s1(ld_s1), .ld_s0(ld_s0),
        .start(start), .pause(pause), .ack(ack),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .running(running), .done(done), .ring(ring), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] cnt();
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [23:0] v);
        {ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0} = v;
    endtask

    task automatic do_load(input logic [23:0] v);
        set_ld(v);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cnt() !== 24'h000000) begin
            errors++; $display("FAIL reset_count got=%h exp=000000", cnt());
        end
        checks++;
        if ({running, done, ring, err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {running, done, ring, err});
        end
    endtask

    task automatic test_full_countdown();
        int done_cnt = 0;
        do_load(24'h000105);
        checks++;
        if (cnt() !== 24'h000105 || running !== 1'b0) begin
            errors++; $display("FAIL load_latency got=%h run=%b exp=000105 run=0", cnt(), running);
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL start_run got=%b exp=1", running);
        end
        tick = 1'b1;
        for (int i = 1; i <= 65; i++) begin
            cycle();
            if (done === 1'b1) done_cnt++;
            if (i == 5) begin
                checks++;
                if (cnt() !== 24'h000100) begin
                    errors++; $display("FAIL cd_tick5 got=%h exp=000100", cnt());
                end
            end
            if (i == 6) begin
                checks++;
                if (cnt() !== 24'h000059) begin
                    errors++; $display("FAIL cd_tick6 got=%h exp=000059", cnt());
                end
            end
            if (i == 64) begin
                checks++;
                if (cnt() !== 24'h000001 || done !== 1'b0 || running !== 1'b1) begin
                    errors++; $display("FAIL cd_tick64 got=%h done=%b run=%b exp=000001 0 1", cnt(), done, running);
                end
            end
            if (i == 65) begin
                checks++;
                if (cnt() !== 24'h000000 || done !== 1'b1 || ring !== 1'b1 || running !== 1'b0) begin
                    errors++; $display("FAIL cd_ring_entry got=%h done=%b ring=%b run=%b exp=000000 1 1 0",
                                       cnt(), done, ring, running);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (done === 1'b1) done_cnt++;
        end
        tick = 1'b0;
        checks++;
        if (done_cnt != 1 || ring !== 1'b1 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL ring_hold done_pulses=%0d ring=%b cnt=%h exp=1 1 000000", done_cnt, ring, cnt());
        end
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        checks++;
        if (ring !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ack_idle ring=%b run=%b done=%b exp=0 0 0", ring, running, done);
        end
    endtask

    task automatic test_hour_borrow();
        do_load(24'h010000);
        do_start();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        checks++;
        if (cnt() !== 24'h005959 || running !== 1'b1) begin
            errors++; $display("FAIL hour_borrow got=%h run=%b exp=005959 1", cnt(), running);
        end
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        do_load(24'h000000);
        checks++;
        if (cnt() !== 24'h000000 || running !== 1'b0) begin
            errors++; $display("FAIL paused_load got=%h run=%b exp=000000 0", cnt(), running);
        end
    endtask

    task automatic test_pause();
        do_load(24'h000012);
        do_start();
        tick = 1'b1;
        repeat (2) cycle();
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        checks++;
        if (cnt() !== 24'h000010 || running !== 1'b0) begin
            errors++; $display("FAIL pause_drop_tick got=%h run=%b exp=000010 0", cnt(), running);
        end
        repeat (3) cycle();
        tick = 1'b0;
        checks++;
        if (cnt() !== 24'h000010) begin
            errors++; $display("FAIL paused_frozen got=%h exp=000010", cnt());
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL resume got=%b exp=1", running);
        end
        tick = 1'b1;
        repeat (3) cycle();
        tick = 1'b0;
        checks++;
        if (cnt() !== 24'h000007) begin
            errors++; $display("FAIL resume_ticks got=%h exp=000007", cnt());
        end
        do_load(24'h000030);
        checks++;
        if (cnt() !== 24'h000007 || running !== 1'b1) begin
            errors++; $display("FAIL run_load_ignored got=%h run=%b exp=000007 1", cnt(), running);
        end
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        set_ld(24'h000020);
        load = 1'b1;
        start = 1'b1;
        cycle();
        load = 1'b0;
        start = 1'b0;
        checks++;
        if (cnt() !== 24'h000020 || running !== 1'b0) begin
            errors++; $display("FAIL paused_load_prio got=%h run=%b exp=000020 0", cnt(), running);
        end
    endtask

    task automatic test_load_reject();
        do_load(24'h000000);
        do_load(24'h000060);
        checks++;
        if (err !== 1'b1 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL reject_s1 err=%b cnt=%h exp=1 000000", err, cnt());
        end
        cycle();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_pulse_width got=%b exp=0", err);
        end
        do_load(24'h240000);
        checks++;
        if (err !== 1'b1 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL reject_h24 err=%b cnt=%h exp=1 000000", err, cnt());
        end
        do_load(24'h23595A);
        checks++;
        if (err !== 1'b1 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL reject_s0 err=%b cnt=%h exp=1 000000", err, cnt());
        end
        do_load(24'h235959);
        checks++;
        if (err !== 1'b0 || cnt() !== 24'h235959) begin
            errors++; $display("FAIL accept_max err=%b cnt=%h exp=0 235959", err, cnt());
        end
        do_load(24'h000000);
        do_start();
        checks++;
        if (running !== 1'b0) begin
            errors++; $display("FAIL start_at_zero run=%b exp=0", running);
        end
    endtask

    task automatic test_load_start_same();
        set_ld(24'h000003);
        load = 1'b1;
        start = 1'b1;
        cycle();
        load = 1'b0;
        start = 1'b0;
        checks++;
        if (cnt() !== 24'h000003 || running !== 1'b0) begin
            errors++; $display("FAIL load_wins got=%h run=%b exp=000003 0", cnt(), running);
        end
        do_start();
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL start_after_load got=%b exp=1", running);
        end
        tick = 1'b1;
        repeat (3) cycle();
        tick = 1'b0;
        checks++;
        if (ring !== 1'b1 || done !== 1'b1 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL short_ring ring=%b done=%b cnt=%h exp=1 1 000000", ring, done, cnt());
        end
        do_load(24'h000045);
        checks++;
        if (ring !== 1'b0 || cnt() !== 24'h000045) begin
            errors++; $display("FAIL ring_load ring=%b cnt=%h exp=0 000045", ring, cnt());
        end
    endtask

    task automatic test_async_reset();
        do_load(24'h123456);
        checks++;
        if (cnt() !== 24'h123456) begin
            errors++; $display("FAIL load_123456 got=%h exp=123456", cnt());
        end
        do_start();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt() !== 24'h000000 || running !== 1'b0) begin
            errors++; $display("FAIL async_rst got=%h run=%b exp=000000 0", cnt(), running);
        end
        tick = 1'b1;
        cycle();
        checks++;
        if (done !== 1'b0 || ring !== 1'b0 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL rst_hold done=%b ring=%b cnt=%h exp=0 0 000000", done, ring, cnt());
        end
        rst = 1'b0;
        cycle();
        tick = 1'b0;
        checks++;
        if (running !== 1'b0 || cnt() !== 24'h000000) begin
            errors++; $display("FAIL post_rst_idle run=%b cnt=%h exp=0 000000", running, cnt());
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
        set_ld(24'h000000);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        test_reset();
        test_full_countdown();
        test_hour_borrow();
        test_pause();
        test_load_reject();
        test_load_start_same();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_down_timer_bcd.md
# cnt_down_timer_bcd

- BCD countdown timer for the alarm-clock design. Counts HH:MM:SS down from a loaded value, one step per 1 Hz enable tick.
- Stops at 00:00:00 and raises a latched ring indication until acknowledged.
- Shares the BCD digit format of the up-counting time-of-day counters, so the display path consumes its outputs unchanged.

## Interface
- H_MAX, 8'h23: largest loadable hour, as packed BCD {tens, ones}.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle enable, 1 Hz; only qualifies decrements.
- load  in  1  load request for the ld_* digits.
- ld_h1, ld_h0, ld_m1, ld_m0, ld_s1, ld_s0  in  4 each  BCD digits to load.
- start  in  1  start or resume request.
- pause  in  1  pause request.
- ack  in  1  ring acknowledge.
- h1, h0, m1, m0, s1, s0  out  4 each  current count, BCD.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse on entry to RING.
- ring  out  1  high in RING.
- err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSED, RING.
- Reset: state IDLE, all digits 0, all flags 0.

Load validation:
- A load is valid only if every digit is ≤ 9, ld_m1 ≤ 5, ld_s1 ≤ 5, and {ld_h1, ld_h0} ≤ H_MAX.
- A rejected load leaves count and state unchanged and pulses err on the next cycle.

IDLE:
- load (valid): latch digits.
- start: go to RUN only if count ≠ 00:00:00; otherwise ignore.
- load and start in the same cycle: load wins, stay IDLE.

RUN:
- tick decrements the count by one second.
- pause: go to PAUSED; a tick in the same cycle is dropped.
- load, start, ack: ignored.
- tick at 00:00:01: count becomes 00:00:00 and state becomes RING.

PAUSED:
- Count frozen; tick ignored.
- start: go to RUN.
- load (valid): latch digits and go to IDLE.
- load has priority over start.

RING:
- Count holds 00:00:00; ring = 1.
- ack or valid load: go to IDLE. A load also latches its digits.

Decrement arithmetic:
- s0 = 0 → s0 = 9 with borrow to s1.
- s1 = 0 with borrow in → s1 = 5 with borrow to minutes.
- Minutes follow the same rule, borrowing to hours.
- Hours: h0 = 0 → h0 = 9, h1 − 1.
- Hours never underflow, because the count stops at zero.
- Every output digit stays valid BCD in every cycle.

## Timing
- All outputs are registered.
- Count changes on the clk edge that samples tick high in RUN, so it is visible 1 cycle after tick.
- done is high exactly in the first cycle where state = RING, which is the same cycle the count reads 00:00:00. ring is asserted in that cycle too.
- Load latency: digits appear 1 cycle after the load is sampled.
- running and ring are state decodes and update in the same cycle as the state.
- rst asserted mid-count clears everything immediately, with no clock edge needed. No done is generated.
- Back-to-back ticks on consecutive cycles must each decrement; there is no minimum tick spacing.

## Structure
- Shared package / include (timer_pkg): state encodings S_IDLE, S_RUN, S_PAUSED, S_RING; BCD limits SEC_TENS_MAX = 5, DIGIT_MAX = 9.
- Sub-module bcd_down_cnt_2d, instantiated three times (seconds, minutes, hours):
  - Parameters: tens and ones wrap values.
  - Inputs: en, load, ld1, ld0.
  - Outputs: d1, d0, is_zero, borrow_out.
  - borrow_out = en & is_zero.
- Top level contains the FSM, load validation, the zero-detect chain and done/err generation.

## Test plan
- Load 00:01:05, start, apply 65 ticks → count passes 00:01:00 → 00:00:59. done pulses once on the 65th tick. ring stays 1 until ack, then state is IDLE.
- Load 01:00:00, start, apply 1 tick → count 00:59:59. All digits remain valid BCD.
- In RUN at 00:00:10, pause and tick in the same cycle → count stays 00:00:10, state PAUSED. Further ticks have no effect. start then 3 ticks → 00:00:07.
- Load with ld_s1 = 6, then with hours 24 → err pulses twice, count unchanged. start at 00:00:00 → stays IDLE.
- In IDLE, load 00:00:03 and start in the same cycle → IDLE with count 00:00:03. start next cycle → RUN.
- Assert rst mid-run at 12:34:56 between clock edges → outputs 0 immediately, state IDLE, no done pulse.
